// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_DW = 16;               // dividend / quotient width
  localparam int DIV_VW = 8;                // divisor / remainder width
  localparam int DIV_CW = $clog2(DIV_DW);   // iteration counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the resulting quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW-1:0] i_pr,       // partial remainder, always < divisor
  input  logic          i_bit,      // next dividend bit, MSB first
  input  logic [VW-1:0] i_divisor,
  output logic [VW-1:0] o_pr,
  output logic          o_qbit
);

  logic [VW:0] w_shift;

  // The shifted value needs VW+1 bits. After a successful subtract the true
  // result is below the divisor, so a VW-bit modular subtract is exact.
  assign w_shift = {i_pr, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  assign o_pr    = o_qbit ? (w_shift[VW-1:0] - i_divisor) : w_shift[VW-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on
// both sides. The dividend register shifts left each step and the quotient
// bits shift in at the bottom, so it holds the quotient when the run ends.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

  div_state_t    r_state;
  div_state_t    w_state_next;
  logic [DW-1:0] r_dq;          // dividend in, quotient out
  logic [VW-1:0] r_divisor;
  logic [VW-1:0] r_pr;          // partial remainder
  logic [CW-1:0] r_cnt;
  logic          r_dbz;
  logic [VW-1:0] w_pr_next;
  logic          w_qbit;
  logic          w_accept;
  logic          w_last_step;

  div_step #(.VW(VW)) u_step (
    .i_pr      (r_pr),
    .i_bit     (r_dq[DW-1]),
    .i_divisor (r_divisor),
    .o_pr      (w_pr_next),
    .o_qbit    (w_qbit)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_last_step = (r_cnt == CW'(DW - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking (<=) in clocked blocks so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_state_next = (divisor == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (w_last_step) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture and one restoring step per BUSY cycle; results hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are plain flops, so they take the async reset
    // too; a reset mid-operation leaves no stale result on the outputs.
    if (!rst_n) begin
      r_dq      <= '0;
      r_divisor <= '0;
      r_pr      <= '0;
      r_cnt     <= '0;
      r_dbz     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_divisor <= divisor;
            r_cnt     <= '0;
            if (divisor == '0) begin
              r_dq  <= '1;
              r_pr  <= dividend[VW-1:0];
              r_dbz <= 1'b1;
            end else begin
              r_dq  <= dividend;
              r_pr  <= '0;
              r_dbz <= 1'b0;
            end
          end
        end
        BUSY: begin
          r_dq  <= {r_dq[DW-2:0], w_qbit};
          r_pr  <= w_pr_next;
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_dq;
  assign remainder   = r_pr;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands,
// expected results queued at issue time and compared by a separate monitor.
module tb_seq_divider;

  localparam int DW = 16;
  localparam int VW = 8;
  // Edges after the accept edge until out_valid is seen: a nonzero divisor
  // needs 16 step edges; a zero divisor is presented right after accept.
  localparam int LAT_NZ = 16;
  localparam int LAT_Z  = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic mon_busy = 1'b0;
  logic rdy_random = 1'b0;
  logic rdy_value  = 1'b1;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer division with the zero-divisor rule.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a[VW-1:0];
      e.dbz = 1'b1;
      e.lat = LAT_Z;
    end else begin
      e.q   = DW'(int'(a) / int'(b));
      e.r   = VW'(int'(a) % int'(b));
      e.dbz = 1'b0;
      e.lat = LAT_NZ;
    end
    return e;
  endfunction

  // out_ready driver: either a fixed level or random backpressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_value;
    end
  end

  // Monitor: samples on the falling edge, pops expectations on each new result.
  initial begin
    logic          have = 1'b0;
    logic          drained_last = 1'b0;
    logic [DW-1:0] hq;
    logic [VW-1:0] hr;
    logic          hd;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        exp_q.delete();
        acc_q.delete();
        have = 1'b0;
        mon_busy = 1'b0;
        drained_last = 1'b0;
      end else begin
        if (drained_last) begin
          check("in_ready_after_drain", 32'(in_ready), 1);
          check("out_valid_after_drain", 32'(out_valid), 0);
        end
        drained_last = 1'b0;
        if (mon_busy) check("in_ready_low_busy", 32'(in_ready), 0);
        if (out_valid) begin
          if (!have) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
              check("spurious_out_valid", 32'(out_valid), 0);
            end else begin
              exp_t e;
              int   acc;
              e   = exp_q.pop_front();
              acc = acc_q.pop_front();
              check("quotient", 32'(quotient), 32'(e.q));
              check("remainder", 32'(remainder), 32'(e.r));
              check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
              check("latency", 32'(ncyc - acc - 1), 32'(e.lat));
              if (e.b != 0) begin
                check("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                check("rem_lt_div", 32'(remainder < e.b), 1);
              end
            end
            have = 1'b1;
            hq = quotient;
            hr = remainder;
            hd = div_by_zero;
          end else begin
            check("hold_quotient", 32'(quotient), 32'(hq));
            check("hold_remainder", 32'(remainder), 32'(hr));
            check("hold_dbz", 32'(div_by_zero), 32'(hd));
          end
          if (out_ready) begin
            have = 1'b0;
            mon_busy = 1'b0;
            drained_last = 1'b1;
          end
        end
        if (in_valid && in_ready) begin
          acc_q.push_back(ncyc);
          mon_busy = 1'b1;
        end
      end
    end
  end

  // Issue one operation; called #1 after a rising edge, returns likewise.
  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int budget = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      budget++;
      if (budget > 200) begin
        check("accept_timeout", 32'(in_ready), 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
    end
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom();
    divisor  = $urandom();
  endtask

  // Wait until every queued result has been seen and drained.
  task automatic wait_idle();
    int budget = 0;
    @(negedge clk);
    while (exp_q.size() != 0 || mon_busy) begin
      budget++;
      if (budget > 300) begin
        check("drain_timeout", 32'(exp_q.size()), 0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int budget;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic nonzero division.
    do_op(16'd1000, 8'd7);
    wait_idle();

    // Back-to-back, second operands presented while the first is in flight.
    do_op(16'hFFFF, 8'd1);
    do_op(16'd5, 8'd9);
    wait_idle();

    // Divide by zero.
    do_op(16'h1234, 8'd0);
    wait_idle();

    // Backpressure: hold out_ready low for 5 cycles after out_valid.
    rdy_value = 1'b0;
    @(posedge clk);
    #1;
    do_op(16'd60000, 8'd255);
    budget = 0;
    @(negedge clk);
    while (!out_valid && budget < 40) begin
      budget++;
      @(negedge clk);
    end
    check("hold_reached_done", 32'(out_valid), 1);
    repeat (5) @(negedge clk);
    rdy_value = 1'b1;
    wait_idle();

    // Reset after 8 BUSY steps discards the operation.
    do_op(16'd40000, 8'd3);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("no_stale_result", 32'(out_valid), 0);
    do_op(16'd40000, 8'd3);
    wait_idle();

    // Random operands with random backpressure and idle gaps.
    rdy_random = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      int            sel;
      a   = DW'($urandom());
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = '0;
      else if (sel == 1) b = 8'd1;
      else if (sel == 2) b = 8'd255;
      else               b = VW'($urandom());
      if (sel == 3) a = '1;
      do_op(a, b);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    rdy_random = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
